// File: rtl/instruction_fetch_stage_if.sv
// Shared types and the instruction-memory handshake bundle for the fetch stage.
package instruction_fetch_stage_pkg;
    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] instruction_t;
endpackage

// Instruction-memory read port: the fetch stage is the master.
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ready;
    instruction_t      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: sequential PC fetch with stall buffering and
// branch redirect/squash that never breaks the memory handshake.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter instruction_t    NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [XLEN-1:0]           branch_target,
    instruction_fetch_stage_if.master imem,
    output instruction_t              instruction,
    output logic [XLEN-1:0]           pc,
    output logic                      valid
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   squash_tgt_q, squash_tgt_d;
    instruction_t      hold_instr_q, hold_instr_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic              req_q, req_d;
    instruction_t      instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;

    logic              fire;
    logic              pending;
    logic [XLEN-1:0]   target;

    // A word is accepted only while our own request is visible on the bus;
    // this also ignores a late ready right after reset.
    assign fire    = req_q && imem.imem_ready;
    assign pending = req_q && !imem.imem_ready;
    assign target  = branch_target & ALIGN_MASK;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc_q;
    assign instruction    = instr_q;
    assign pc             = pc_q;
    assign valid          = valid_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (branch_taken) begin
                    state_d = pending ? ST_SQUASH : ST_REQ;
                end else if (fire && stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_taken || !stall) begin
                    state_d = ST_REQ;
                end
            end
            ST_SQUASH: begin
                if (imem.imem_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        squash_tgt_d = squash_tgt_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        req_d        = (state_d != ST_HOLD);

        case (state_q)
            ST_REQ: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (pending) begin
                        squash_tgt_d = target;
                    end else begin
                        fetch_pc_d = target;
                    end
                end else if (fire) begin
                    fetch_pc_d = XLEN'(fetch_pc_q + PC_STEP);
                    if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = fetch_pc_q;
                    end else begin
                        instr_d = imem.imem_rdata;
                        pc_d    = fetch_pc_q;
                        valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    valid_d      = 1'b0;
                    instr_d      = NOP_INSTR;
                    fetch_pc_d   = target;
                    hold_instr_d = NOP_INSTR;
                    hold_pc_d    = '0;
                end else if (!stall) begin
                    instr_d      = hold_instr_q;
                    pc_d         = hold_pc_q;
                    valid_d      = 1'b1;
                    hold_instr_d = NOP_INSTR;
                    hold_pc_d    = '0;
                end
            end
            ST_SQUASH: begin
                // Address stays on the bus until the discarded word returns.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (branch_taken) begin
                    squash_tgt_d = target;
                end
                if (imem.imem_ready) begin
                    fetch_pc_d = branch_taken ? target : squash_tgt_q;
                end
            end
            default: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            squash_tgt_q <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            req_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= '0;
            valid_q      <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            squash_tgt_q <= squash_tgt_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            req_q        <= req_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench: directed scenarios plus random traffic checked by a
// stream-level scoreboard (expected next PC, held outputs, bus stability).
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          RAND_CYCLES = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic [31:0]  branch_target = '0;
    logic         mem_ready = 1'b0;
    instruction_t instruction;
    logic [31:0]  pc;
    logic         valid;

    instruction_fetch_stage_if imem_bus();

    instruction_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_bus),
        .instruction   (instruction),
        .pc            (pc),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: word is a function of the address, garbage when not ready.
    assign imem_bus.imem_ready = mem_ready;
    assign imem_bus.imem_rdata = mem_ready ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;

    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        pend = 1'b0;
    logic [31:0] pend_tgt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; afterwards checks the stream rules against pre-edge inputs.
    task automatic tick();
        logic        p_rst, p_stall, p_branch, p_req, p_ready, p_valid;
        logic [31:0] p_tgt, p_addr, p_instr, p_pc;
        p_rst    = rst;
        p_stall  = stall;
        p_branch = branch_taken;
        p_tgt    = branch_target & ~32'h3;
        p_req    = imem_bus.imem_req;
        p_ready  = mem_ready;
        p_addr   = imem_bus.imem_addr;
        p_valid  = valid;
        p_instr  = instruction;
        p_pc     = pc;
        @(posedge clk);
        #1;
        if (p_rst && rst) begin
            if (p_branch) begin
                pend     = 1'b1;
                pend_tgt = p_tgt;
                exp_pc   = p_tgt;
            end
            if (p_req && !p_ready) begin
                check_eq("req_held", 32'(imem_bus.imem_req), 32'd1);
                check_eq("addr_held", imem_bus.imem_addr, p_addr);
            end else if (pend) begin
                check_eq("redirect_addr", imem_bus.imem_addr, pend_tgt);
                pend = 1'b0;
            end
            if (p_branch) begin
                check_eq("flush_valid", 32'(valid), 32'd0);
                check_eq("flush_nop", instruction, NOP_INSTR);
            end else if (p_stall) begin
                check_eq("stall_valid", 32'(valid), 32'(p_valid));
                check_eq("stall_instr", instruction, p_instr);
                check_eq("stall_pc", pc, p_pc);
            end else if (valid) begin
                check_eq("stream_pc", pc, exp_pc);
                check_eq("stream_instr", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                check_eq("bubble_nop", instruction, NOP_INSTR);
            end
        end
    endtask

    task automatic reset_dut();
        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        #1;
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_instr", instruction, NOP_INSTR);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check_eq("rst_addr", imem_bus.imem_addr, RESET_PC);
        repeat (2) tick();
        rst    = 1'b1;
        exp_pc = RESET_PC;
        pend   = 1'b0;
    endtask

    initial begin
        #2;
        // Streaming from reset, memory always ready.
        mem_ready = 1'b1;
        reset_dut();
        tick();
        check_eq("first_req", 32'(imem_bus.imem_req), 32'd1);
        check_eq("first_addr", imem_bus.imem_addr, RESET_PC);
        check_eq("first_edge_valid", 32'(valid), 32'd0);
        tick();
        check_eq("first_valid", 32'(valid), 32'd1);
        check_eq("first_pc", pc, 32'h0);
        tick();
        check_eq("second_pc", pc, 32'h4);
        check_eq("addr_8", imem_bus.imem_addr, 32'h8);

        // Memory not ready for three cycles at 0x8.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("wait_addr", imem_bus.imem_addr, 32'h8);
            check_eq("wait_valid", 32'(valid), 32'd0);
            check_eq("wait_instr", instruction, NOP_INSTR);
        end
        mem_ready = 1'b1;
        tick();
        check_eq("after_wait_pc", pc, 32'h8);
        check_eq("after_wait_valid", 32'(valid), 32'd1);

        // Four stalled cycles with memory ready: one word buffered.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_req", 32'(imem_bus.imem_req), 32'd0);
            check_eq("hold_addr", imem_bus.imem_addr, 32'h10);
            check_eq("hold_pc", pc, 32'h8);
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("release_pc", pc, 32'hC + 32'(i * 4));
            check_eq("release_valid", 32'(valid), 32'd1);
        end

        // Branch to unaligned 0x103 while a request is outstanding.
        mem_ready     = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        tick();
        check_eq("squash_valid", 32'(valid), 32'd0);
        mem_ready = 1'b1;
        tick();
        check_eq("squash_exit_addr", imem_bus.imem_addr, 32'h100);
        check_eq("squash_exit_valid", 32'(valid), 32'd0);
        tick();
        check_eq("target_pc", pc, 32'h100);
        check_eq("target_valid", 32'(valid), 32'd1);

        // Address wrap at the top of memory.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        tick();
        branch_taken = 1'b0;
        repeat (3) tick();
        check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_instr", instruction, mem_word(32'h0));

        // Branch out of HOLD, then reset in the middle of a request.
        stall = 1'b1;
        tick();
        check_eq("hold2_req", 32'(imem_bus.imem_req), 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        check_eq("hold_flush_addr", imem_bus.imem_addr, 32'h200);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        check_eq("post_hold_pc", pc, 32'h200);
        stall     = 1'b1;
        mem_ready = 1'b0;
        tick();
        check_eq("pre_rst_valid", 32'(valid), 32'd1);
        mem_ready = 1'b1;
        reset_dut();
        tick();
        check_eq("late_ready_valid", 32'(valid), 32'd0);
        check_eq("late_ready_addr", imem_bus.imem_addr, RESET_PC);
        tick();
        check_eq("resume_pc", pc, RESET_PC);
        check_eq("resume_instr", instruction, mem_word(RESET_PC));

        // Random traffic.
        for (int n = 0; n < RAND_CYCLES; n++) begin
            if ($urandom_range(0, 599) == 0) reset_dut();
            stall         = ($urandom_range(0, 9) < 3);
            mem_ready     = ($urandom_range(0, 9) < 6);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = $urandom();
            if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            tick();
        end
        check_eq("delivered_min", 32'(delivered >= 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble encoding driven when no valid instruction is present (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  downstream (decode) cannot accept; hold the outputs.
REQ-006 branch_taken  input  1  redirect/flush request from execute.
REQ-007 branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  word-aligned read address.
REQ-010 imem_ready  input  1  read completes this cycle; imem_rdata valid.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instruction  output  instruction_t (32)  instruction word to the decode stage.
REQ-013 pc  output  32  address of instruction.
REQ-014 valid  output  1  instruction/pc hold a real fetched instruction.

Function
REQ-015 The FSM SHALL have the states REQ (request outstanding), HOLD (word captured, downstream stalled) and SQUASH (outstanding request to be discarded).
REQ-016 fetch_pc SHALL be an internal 32-bit register; imem_addr = fetch_pc at all times.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ready=1.
REQ-018 REQ + imem_ready + stall=0: next edge loads instruction<=imem_rdata, pc<=fetch_pc, valid<=1 and fetch_pc<=fetch_pc+4; state stays REQ; throughput is 1 instr/cycle when memory is ready every cycle.
REQ-019 REQ + imem_ready + stall=1: the word and its address go to a hold buffer; fetch_pc<=fetch_pc+4; the state goes to HOLD; instruction/pc/valid are unchanged.
REQ-020 REQ, no imem_ready, stall=0: next edge drives a bubble: valid<=0, instruction<=NOP_INSTR, pc unchanged.
REQ-021 While stall=1 (without a flush), instruction/pc/valid SHALL hold their values.
REQ-022 HOLD: imem_req=0; when stall=0, the next edge moves the hold buffer to the outputs (valid<=1) and the state returns to REQ.
REQ-023 branch_taken=1 SHALL override stall; on the next edge valid<=0, instruction<=NOP_INSTR, the hold buffer is discarded and fetch_pc<=branch_target&~3.
REQ-024 branch_taken in REQ with imem_ready=1 in the same cycle: the returned word is discarded; the state stays REQ at the target.
REQ-025 branch_taken in REQ with imem_ready=0: the state goes to SQUASH.
REQ-026 In SQUASH, imem_req SHALL stay 1 and imem_addr SHALL stay at the old address until imem_ready, preserving the memory handshake.
REQ-027 In SQUASH, on imem_ready the word is dropped and the next edge enters REQ with imem_addr = target.
REQ-028 In SQUASH, outputs SHALL stay bubbles (valid=0).
REQ-029 branch_taken while in SQUASH SHALL replace the pending target; the newest target wins.
REQ-030 branch_taken in HOLD SHALL clear the buffer and enter REQ at the target.
REQ-031 fetch_pc and pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no error.
REQ-032 An instruction SHALL never be duplicated or skipped except by the flush rules above.

Reset
REQ-033 While rst=0, asynchronously: state=REQ, fetch_pc=RESET_PC, imem_req=0, instruction=NOP_INSTR, pc=0, valid=0, hold buffer empty.
REQ-034 imem_req SHALL first assert on the first rising edge after rst deasserts, at RESET_PC.
REQ-035 Reset asserted mid-request or in SQUASH/HOLD SHALL abandon all pending state; a late imem_ready after reset is ignored until the first new request.

Verification
REQ-036 Reset release, imem_ready=1 every cycle, memory word = address -> pc/instruction = 0,4,8,... on consecutive cycles with valid=1, first valid output 2 edges after release.
REQ-037 imem_ready=0 for 3 cycles at address 0x8 -> imem_addr held at 0x8, 3 bubbles (valid=0, instr=0x13), then pc=0x8 valid=1.
REQ-038 stall=1 for 4 cycles while ready -> outputs frozen, exactly one word buffered (HOLD, imem_req=0); on release pc advances by 4 each cycle with no gap or duplicate.
REQ-039 branch_taken, target 0x103 with request outstanding and ready 2 cycles later -> late word dropped, next imem_addr=0x100, first valid pc=0x100, no stale instruction ever valid.
REQ-040 branch_taken with stall=1 in HOLD, then rst pulsed low mid-request -> valid=0 immediately, fetch resumes at RESET_PC, pre-reset data never output.
